// File: rtl/count_run_controller.sv
// Run/pause/lap sequencer for the 8-bit enable/clear counter: debounced keys,
// prescaled count ticks, terminal-count handling and display value selection.
module count_run_controller #(
    parameter int unsigned PRESCALE = 50_000_000,
    parameter int unsigned DEBOUNCE = 500_000,
    parameter logic [7:0]  TERM     = 8'hFF,
    parameter bit          WRAP     = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_start_n,
    input  logic       key_clear_n,
    input  logic       key_lap_n,
    input  logic [7:0] count,
    output logic       cnt_enable,
    output logic       cnt_clear_n,
    output logic [7:0] disp_value,
    output logic       running,
    output logic       lap_active,
    output logic       done
);

    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned     DB_W    = $clog2(DEBOUNCE + 1);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Key bit order: 0 start, 1 clear, 2 lap
    logic [2:0]           keys_s;
    logic [2:0]           sync1_r;
    logic [2:0]           sync2_r;
    logic [2:0]           filt_r;
    logic [2:0]           press_r;
    logic [2:0][DB_W-1:0] db_cnt_r;

    logic                 start_ev_s;
    logic                 clear_ev_s;
    logic                 lap_ev_s;
    logic                 slot_s;
    logic                 term_s;

    state_t               state_r;
    logic [PS_W-1:0]      prescale_r;
    logic [7:0]           lap_r;
    logic                 cnt_enable_r;
    logic                 cnt_clear_n_r;
    logic [7:0]           disp_value_r;
    logic                 running_r;
    logic                 lap_active_r;
    logic                 done_r;

    assign keys_s = {key_lap_n, key_clear_n, key_start_n};

    // Two-flop synchronizers for the asynchronous pushbuttons
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_r <= 3'b111;
            sync2_r <= 3'b111;
        end else begin
            sync1_r <= keys_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce filters; a press pulse is emitted on the accepted 1->0 change
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            filt_r   <= 3'b111;
            press_r  <= 3'b000;
            db_cnt_r <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                press_r[i] <= 1'b0;
                if (sync2_r[i] != filt_r[i]) begin
                    if (db_cnt_r[i] == DB_LAST) begin
                        filt_r[i]   <= sync2_r[i];
                        db_cnt_r[i] <= '0;
                        press_r[i]  <= filt_r[i];
                    end else begin
                        db_cnt_r[i] <= db_cnt_r[i] + 1'b1;
                    end
                end else begin
                    db_cnt_r[i] <= '0;
                end
            end
        end
    end

    assign start_ev_s = press_r[0];
    assign clear_ev_s = press_r[1];
    assign lap_ev_s   = press_r[2];
    assign slot_s     = (prescale_r == PS_LAST);
    assign term_s     = (count == TERM);

    // Sequencer FSM with registered tick, clear and status outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            prescale_r    <= '0;
            lap_r         <= 8'h00;
            cnt_enable_r  <= 1'b0;
            cnt_clear_n_r <= 1'b1;
            running_r     <= 1'b0;
            lap_active_r  <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            cnt_enable_r  <= 1'b0;
            cnt_clear_n_r <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (clear_ev_s) begin
                        cnt_clear_n_r <= 1'b0;
                        prescale_r    <= '0;
                        lap_active_r  <= 1'b0;
                    end else if (start_ev_s) begin
                        state_r    <= ST_RUN;
                        running_r  <= 1'b1;
                        prescale_r <= '0;
                    end
                end
                ST_RUN, ST_PAUSE: begin
                    if (clear_ev_s) begin
                        state_r       <= ST_IDLE;
                        running_r     <= 1'b0;
                        cnt_clear_n_r <= 1'b0;
                        prescale_r    <= '0;
                        lap_active_r  <= 1'b0;
                    end else begin
                        if (state_r == ST_PAUSE) begin
                            if (start_ev_s) begin
                                state_r   <= ST_RUN;
                                running_r <= 1'b1;
                            end
                        end else if (start_ev_s) begin
                            // Pausing in the slot holds it, so resume ticks first
                            state_r   <= ST_PAUSE;
                            running_r <= 1'b0;
                        end else if (slot_s) begin
                            prescale_r <= '0;
                            if (!term_s) begin
                                cnt_enable_r <= 1'b1;
                            end else if (WRAP) begin
                                cnt_clear_n_r <= 1'b0;
                            end else begin
                                state_r   <= ST_DONE;
                                running_r <= 1'b0;
                                done_r    <= 1'b1;
                            end
                        end else begin
                            prescale_r <= prescale_r + 1'b1;
                        end
                        if (lap_ev_s) begin
                            lap_active_r <= !lap_active_r;
                            if (!lap_active_r) begin
                                lap_r <= count;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (clear_ev_s) begin
                        state_r       <= ST_IDLE;
                        done_r        <= 1'b0;
                        cnt_clear_n_r <= 1'b0;
                        prescale_r    <= '0;
                        lap_active_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    running_r    <= 1'b0;
                    done_r       <= 1'b0;
                    prescale_r   <= '0;
                    lap_active_r <= 1'b0;
                end
            endcase
        end
    end

    // Display register: lap value while lap mode is active, live count otherwise
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_value_r <= 8'h00;
        end else begin
            disp_value_r <= lap_active_r ? lap_r : count;
        end
    end

    assign cnt_enable  = cnt_enable_r;
    assign cnt_clear_n = cnt_clear_n_r;
    assign disp_value  = disp_value_r;
    assign running     = running_r;
    assign lap_active  = lap_active_r;
    assign done        = done_r;

endmodule

// File: doc/count_run_controller.md
# count_run_controller

Run/pause/lap sequencer for the 8-bit enable/clear counter datapath. It turns raw active-low pushbuttons into debounced press events and generates the counter's enable ticks from a prescaler. It also drives the counter's clear, handles the terminal count, and selects the live or lap-latched value that goes to the hex display decoders. It sits between the board keys and the counter/seven-segment path.

## Interface
- PRESCALE, 50_000_000: clock cycles per count tick; must be at least 2.
- DEBOUNCE, 500_000: consecutive stable synchronized samples required to accept a key level; must be at least 1.
- TERM, 8'hFF: terminal count value.
- WRAP, 1: 1 = clear and keep running at terminal; 0 = stop in DONE.

- clock  in  1  rising-edge system clock.
- reset  in  1  reset, asynchronous, active-low.
- key_start_n  in  1  start/pause toggle pushbutton, active-low, asynchronous.
- key_clear_n  in  1  clear pushbutton, active-low, asynchronous.
- key_lap_n  in  1  lap toggle pushbutton, active-low, asynchronous.
- count  in  8  current counter value, synchronous to clock.
- cnt_enable  out  1  one-cycle count tick to the counter.
- cnt_clear_n  out  1  one-cycle active-low clear to the counter.
- disp_value  out  8  value for the display decoders.
- running  out  1  high in RUN.
- lap_active  out  1  high while the display shows the latched lap value.
- done  out  1  high in DONE.

## Operation
- **Key path**
  - Each key passes through a 2-flop synchronizer (reset value 1), then a debounce filter.
  - The filtered level changes only after DEBOUNCE consecutive identical synchronized samples.
  - A press event is a one-cycle pulse generated when the filtered level goes 1 to 0. Release generates nothing.
- **States:** IDLE, RUN, PAUSE, DONE. Reset state is IDLE.
- **IDLE**
  - start goes to RUN with the prescaler at 0.
  - clear emits a clear pulse and stays in IDLE.
  - lap is ignored.
- **RUN**
  - The prescaler counts 0..PRESCALE-1 and then wraps.
  - At prescaler == PRESCALE-1 (the tick slot), one of three things happens:
    - count != TERM: cnt_enable pulses.
    - count == TERM and WRAP=1: cnt_clear_n pulses instead of cnt_enable, and the state stays RUN.
    - count == TERM and WRAP=0: no pulse, and the state goes to DONE.
  - start goes to PAUSE. The prescaler holds its value.
  - clear goes to IDLE, emits a clear pulse, resets the prescaler and clears lap_active.
- **PAUSE**
  - No ticks are issued.
  - start goes to RUN and the prescaler resumes from the held value.
  - clear behaves as in RUN.
- **DONE**
  - No ticks; start and lap are ignored.
  - clear goes to IDLE, emits a clear pulse and clears lap_active.
- **Lap** (RUN and PAUSE only)
  - A lap event toggles lap_active.
  - On the 0 to 1 toggle, count is captured into the lap register.
- **Display:** disp_value is registered. Each cycle it loads the lap register if lap_active is high, otherwise count.
- **Priority**
  - clear overrides start and lap in the same cycle.
  - start and lap in the same cycle are both applied. The lap captures count from that cycle.
  - A clear event coinciding with a tick slot suppresses the tick.
  - cnt_enable and cnt_clear_n are never active in the same cycle.

## Timing
- All registers update on the rising edge of clock. reset asynchronously forces every register to its reset value.
- Reset values:
  - Internal: state IDLE, prescaler 0, lap register 0, sync/filter flops 1.
  - Outputs: cnt_enable 0, cnt_clear_n 1, disp_value 0, running 0, lap_active 0, done 0.
- **Key latency:** for a clean key held low, the state and outputs change on the (DEBOUNCE+3)th rising edge after the first edge that samples the key low.
- **Tick spacing**
  - The first tick after IDLE to RUN is asserted in the PRESCALE-th cycle after the transition edge.
  - Later ticks are exactly PRESCALE cycles apart.
  - Pause time does not count toward tick spacing.
- **Clear pulse:** cnt_clear_n is low for exactly one cycle, in the cycle after the event edge.
- **Terminal compare:** uses count as sampled in the tick-slot cycle. The counter must reflect the previous tick by then, which holds because PRESCALE is at least 2.
- **Display latency:** disp_value lags count or the lap register by 1 cycle.
- **Status flags:** running and done are registered state decodes, valid in the same cycle as the state.
- **Reset mid-operation:** returns immediately to IDLE with reset values. An in-progress debounce restarts.

## Test plan
All scenarios use PRESCALE=4, DEBOUNCE=2, TERM=8'h05, with the bench modelling the 8-bit counter.

- Reset asserted mid-RUN → all outputs take reset values within the same cycle; after release, state is IDLE and there are no ticks.
- start press, WRAP=1 → running goes high on edge 5 after the key is sampled low; cnt_enable pulses every 4 cycles; count goes 0→5; at count 5 the next slot gives cnt_clear_n low instead of enable, count returns to 0, and running stays 1.
- start press, WRAP=0 → after count reaches 5, the next tick slot gives no pulse and done goes to 1; start and lap are ignored; clear gives a one-cycle clear pulse and done=0.
- start press; lap press at count 3 → lap_active=1 and disp_value holds 3 while count advances; second lap press → disp_value tracks live count one cycle behind.
- start press, then pause after 2 ticks plus 2 prescaler cycles; hold 20 cycles; start again → no ticks while paused; the next tick comes 2 cycles after resume.
- Key bounce of 1 cycle low, then high → no event. Simultaneous clear+start in RUN → IDLE plus one clear pulse, no tick, running=0.
